// File: rtl/spi_multi_pkg.sv
// Shared definitions for spi_master_multi_mode: FSM encoding, MODE_VEC field
// indices and the per-byte half-period counter width.
package spi_multi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_SETUP,
    ST_SHIFT,
    ST_NEXT,
    ST_HOLD,
    ST_GAP
  } state_e;

  localparam int CPOL_IDX      = 1;
  localparam int CPHA_IDX      = 0;
  localparam int BIT_CNT_W     = 4;
  localparam int HALF_PER_BYTE = 16;

endpackage

// File: rtl/spi_half_tick.sv
// SCLK half-period timebase: down-counter that pulses tick_o for one cycle
// every CLK_DIV cycles; restart_i reloads it so the next tick is CLK_DIV away.
module spi_half_tick #(
  parameter int CLK_DIV = 2
) (
  input  logic sclk_common,
  input  logic n_rst,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge sclk_common or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= RELOAD;
    end else if (restart_i || (cnt_q == '0)) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign tick_o = (cnt_q == '0) && !restart_i;

endmodule

// File: rtl/spi_master_multi_mode.sv
// Multi-slave SPI master with per-slave CPOL/CPHA and explicit frame boundaries.
// Define SPI_3WIRE_EN for half-duplex operation on sdio_i/sdio_o/sdio_oe.
module spi_master_multi_mode
  import spi_multi_pkg::*;
#(
  parameter int                    N_SLAVES = 3,
  parameter int                    SLV_W    = 4,
  parameter logic [2*N_SLAVES-1:0] MODE_VEC = '0,
  parameter int                    CLK_DIV  = 2,
  parameter int                    CS_SETUP = 1,
  parameter int                    CS_HOLD  = 1,
  parameter int                    CS_GAP   = 2,
  parameter int                    SWAP_BIT = 8
) (
  input  logic                sclk_common,
  input  logic                n_rst,
  input  logic [7:0]          m_data,
  input  logic [SLV_W-1:0]    m_slave,
  input  logic                m_last,
  input  logic                m_valid,
  output logic                m_ready,
  output logic [7:0]          s_data,
  output logic [SLV_W-1:0]    s_slave,
  output logic                s_last,
  output logic                s_valid,
  output logic                err,
  output logic                busy,
  output logic [N_SLAVES-1:0] n_cs_bus,
  output logic                sclk,
  output logic                mosi,
`ifdef SPI_3WIRE_EN
  input  logic                sdio_i,
  output logic                sdio_o,
  output logic                sdio_oe,
`endif
  input  logic                miso
);

  localparam logic [SLV_W:0] N_SLV = (SLV_W + 1)'(N_SLAVES);

  state_e                 state_q;
  logic [SLV_W-1:0]       slv_q, s_slave_q;
  logic                   cpha_q, last_q, samp_q;
  logic [7:0]             sh_q, s_data_q;
  logic [BIT_CNT_W-1:0]   hp_q;
  logic [7:0]             cnt_q;
  logic                   sclk_q, mosi_q, s_last_q, s_valid_q, err_q;
  logic [N_SLAVES-1:0]    ncs_q;
  logic                   accept, bad_slv, tick, rx_in;
  logic [1:0]             mode_sel;
  logic [7:0]             rx_byte;
  logic [1:0]             mode_tab [2**SLV_W];

  for (genvar i = 0; i < 2**SLV_W; i++) begin : g_mode
    if (i < N_SLAVES) begin : g_on
      assign mode_tab[i] = MODE_VEC[2*i +: 2];
    end else begin : g_off
      assign mode_tab[i] = 2'b00;
    end
  end

  assign m_ready  = (state_q == ST_IDLE) || (state_q == ST_NEXT);
  assign busy     = (state_q != ST_IDLE);
  assign accept   = m_valid && m_ready;
  assign bad_slv  = ({1'b0, m_slave} >= N_SLV);
  assign mode_sel = mode_tab[m_slave];
  assign rx_byte  = {sh_q[6:0], cpha_q ? rx_in : samp_q};

  spi_half_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .sclk_common(sclk_common),
    .n_rst      (n_rst),
    .restart_i  (accept),
    .tick_o     (tick)
  );

`ifdef SPI_3WIRE_EN
  localparam int FB_W = $clog2(SWAP_BIT + 1);
  logic [FB_W-1:0] fb_q;
  logic            oe_q;
  logic            unused_miso;
  assign rx_in       = sdio_i;
  assign mosi        = 1'b0;
  assign sdio_o      = mosi_q;
  assign sdio_oe     = oe_q;
  assign unused_miso = miso;
`else
  logic unused_swap;
  assign rx_in       = miso;
  assign mosi        = mosi_q;
  assign unused_swap = ^SWAP_BIT;
`endif

  always_ff @(posedge sclk_common or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= ST_IDLE;
      slv_q     <= '0;
      cpha_q    <= 1'b0;
      last_q    <= 1'b0;
      samp_q    <= 1'b0;
      sh_q      <= '0;
      hp_q      <= '0;
      cnt_q     <= '0;
      sclk_q    <= MODE_VEC[CPOL_IDX];
      mosi_q    <= 1'b0;
      ncs_q     <= '1;
      s_data_q  <= '0;
      s_slave_q <= '0;
      s_last_q  <= 1'b0;
      s_valid_q <= 1'b0;
      err_q     <= 1'b0;
`ifdef SPI_3WIRE_EN
      fb_q      <= '0;
      oe_q      <= 1'b0;
`endif
    end else begin
      s_valid_q <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        ST_IDLE: if (m_valid) begin
          if (bad_slv) begin
            err_q <= 1'b1;
          end else begin
            slv_q   <= m_slave;
            cpha_q  <= mode_sel[CPHA_IDX];
            sclk_q  <= mode_sel[CPOL_IDX];
            sh_q    <= m_data;
            last_q  <= m_last;
            state_q <= ST_PREP;
          end
        end
        ST_PREP: if (tick) begin
          ncs_q   <= ~(N_SLAVES'(1) << slv_q);
          if (!cpha_q) mosi_q <= sh_q[7];
          cnt_q   <= 8'(CS_SETUP - 1);
          state_q <= ST_SETUP;
`ifdef SPI_3WIRE_EN
          fb_q    <= '0;
          oe_q    <= 1'b1;
`endif
        end
        ST_SETUP: if (tick) begin
          if (cnt_q == 8'd0) begin
            hp_q    <= '0;
            state_q <= ST_SHIFT;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        ST_SHIFT: if (tick) begin
          sclk_q <= ~sclk_q;
          hp_q   <= hp_q + BIT_CNT_W'(1);
          // even half-period index = leading edge, odd = trailing edge
          if (!hp_q[0]) begin
            if (cpha_q) mosi_q <= sh_q[7];
            else        samp_q <= rx_in;
          end else begin
            sh_q <= rx_byte;
            if (!cpha_q) mosi_q <= sh_q[6];
`ifdef SPI_3WIRE_EN
            if (fb_q == FB_W'(SWAP_BIT - 1)) oe_q <= 1'b0;
            if (fb_q != FB_W'(SWAP_BIT))     fb_q <= fb_q + FB_W'(1);
`endif
          end
          if (hp_q == BIT_CNT_W'(HALF_PER_BYTE - 1)) begin
            s_valid_q <= 1'b1;
            s_data_q  <= rx_byte;
            s_slave_q <= slv_q;
            s_last_q  <= last_q;
            cnt_q     <= 8'(CS_HOLD - 1);
            state_q   <= last_q ? ST_HOLD : ST_NEXT;
          end
        end
        ST_NEXT: if (m_valid) begin
          sh_q    <= m_data;
          last_q  <= m_last;
          hp_q    <= '0;
          if (!cpha_q) mosi_q <= m_data[7];
          state_q <= ST_SHIFT;
        end
        ST_HOLD: if (tick) begin
          if (cnt_q == 8'd0) begin
            ncs_q   <= '1;
            cnt_q   <= 8'(CS_GAP - 1);
            state_q <= ST_GAP;
`ifdef SPI_3WIRE_EN
            oe_q    <= 1'b0;
`endif
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        ST_GAP: if (tick) begin
          if (cnt_q == 8'd0) state_q <= ST_IDLE;
          else               cnt_q   <= cnt_q - 8'd1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_data   = s_data_q;
  assign s_slave  = s_slave_q;
  assign s_last   = s_last_q;
  assign s_valid  = s_valid_q;
  assign err      = err_q;
  assign n_cs_bus = ncs_q;
  assign sclk     = sclk_q;

endmodule

// File: tb/tb_spi_master_multi_mode.sv
// Directed bench for spi_master_multi_mode: slaves 0/1 in mode 0, slave 2 in mode 3.
`timescale 1ns/1ps
module tb_spi_master_multi_mode;

  localparam logic [5:0] MV = 6'b11_00_00;

  logic       sclk_common = 1'b0;
  logic       n_rst = 1'b0;
  logic [7:0] m_data;
  logic [3:0] m_slave;
  logic       m_last, m_valid, m_ready;
  logic [7:0] s_data;
  logic [3:0] s_slave;
  logic       s_last, s_valid, err, busy;
  logic [2:0] n_cs_bus;
  logic       sclk, mosi, miso;
  logic       loop_en, miso_fix;
`ifdef SPI_3WIRE_EN
  logic       sdio_i = 1'b0;
  logic       sdio_o, sdio_oe;
  logic [15:0] tw_pat = 16'h003C;
  int         tw_idx = 0;
  int         oe_hi = 0;
  logic       oe_sv[$];
`endif

  assign miso = loop_en ? mosi : miso_fix;

  spi_master_multi_mode #(
    .N_SLAVES(3), .SLV_W(4), .MODE_VEC(MV), .CLK_DIV(2),
    .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(2), .SWAP_BIT(8)
  ) dut (
    .sclk_common(sclk_common), .n_rst(n_rst),
    .m_data(m_data), .m_slave(m_slave), .m_last(m_last),
    .m_valid(m_valid), .m_ready(m_ready),
    .s_data(s_data), .s_slave(s_slave), .s_last(s_last), .s_valid(s_valid),
    .err(err), .busy(busy), .n_cs_bus(n_cs_bus), .sclk(sclk), .mosi(mosi),
`ifdef SPI_3WIRE_EN
    .sdio_i(sdio_i), .sdio_o(sdio_o), .sdio_oe(sdio_oe),
`endif
    .miso(miso)
  );

  always #5 sclk_common = ~sclk_common;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int rises, cs_low, cs_rise_cyc, cs_rises, sv_cnt, err_cnt, busy_cnt, multi_low;
  logic       sclk_prev = 1'b0;
  logic [2:0] ncs_prev = 3'b111;
  logic [2:0] low_pat;
  logic [7:0] rx_q[$];
  logic [3:0] sl_q[$];
  logic       last_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge sclk_common) cyc <= cyc + 1;

  always @(negedge sclk_common) begin
    if (sclk && !sclk_prev) rises++;
`ifdef SPI_3WIRE_EN
    if (n_cs_bus[0]) tw_idx = 0;
    else if (!sclk && sclk_prev) tw_idx++;
    sdio_i = (tw_idx < 16) ? tw_pat[15 - tw_idx] : 1'b0;
    if (sdio_oe) oe_hi++;
`endif
    sclk_prev = sclk;
    if (n_cs_bus != 3'b111) begin
      cs_low++;
      low_pat = n_cs_bus;
    end
    if (n_cs_bus == 3'b111 && ncs_prev != 3'b111) begin
      cs_rise_cyc = cyc;
      cs_rises++;
    end
    ncs_prev = n_cs_bus;
    if ($countones(~n_cs_bus) > 1) multi_low++;
    if (s_valid) begin
      sv_cnt++;
      rx_q.push_back(s_data);
      sl_q.push_back(s_slave);
      last_q.push_back(s_last);
`ifdef SPI_3WIRE_EN
      oe_sv.push_back(sdio_oe);
`endif
    end
    if (err)  err_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic clear_mon();
    rises = 0; cs_low = 0; cs_rise_cyc = 0; cs_rises = 0;
    sv_cnt = 0; err_cnt = 0; busy_cnt = 0; low_pat = 3'b111;
    rx_q.delete(); sl_q.delete(); last_q.delete();
  endtask

  task automatic send(input logic [7:0] d, input logic [3:0] sl, input logic lst);
    int n = 0;
    @(negedge sclk_common);
    m_data = d; m_slave = sl; m_last = lst; m_valid = 1'b1;
    while (!m_ready && n < 2000) begin
      @(negedge sclk_common);
      n++;
    end
    if (!m_ready) check_eq("send_timeout", m_ready, 1);
    @(posedge sclk_common);
    #1;
    acc_cyc = cyc;
    m_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 1000) begin
      @(negedge sclk_common);
      n++;
    end
    if (busy) check_eq("idle_timeout", busy, 0);
    repeat (2) @(negedge sclk_common);
  endtask

  task automatic wait_next();
    int n = 0;
    while (!(busy && m_ready) && n < 500) begin
      @(negedge sclk_common);
      n++;
    end
    if (!(busy && m_ready)) check_eq("next_timeout", m_ready, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad;
    m_data = '0; m_slave = '0; m_last = 1'b0; m_valid = 1'b0;
    loop_en = 1'b1; miso_fix = 1'b0; multi_low = 0;
    clear_mon();

    repeat (3) @(posedge sclk_common);
    #1;
    check_eq("rst_ncs", n_cs_bus, 3'b111);
    check_eq("rst_sclk", sclk, 0);
    check_eq("rst_mosi", mosi, 0);
    check_eq("rst_ready", m_ready, 1);
    check_eq("rst_valid", s_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_sdata", {s_last, s_slave, s_data}, 0);
    @(negedge sclk_common);
    n_rst = 1'b1;

    // single byte, slave 0 mode 0, loopback
    clear_mon();
    send(8'hA5, 4'd0, 1'b1);
    wait_idle();
    check_eq("t1_rises", rises, 8);
    check_eq("t1_svcnt", sv_cnt, 1);
    check_eq("t1_data", rx_q[0], 8'hA5);
    check_eq("t1_slave", sl_q[0], 0);
    check_eq("t1_last", last_q[0], 1);
    check_eq("t1_cs_pat", low_pat, 3'b110);
    check_eq("t1_cs_low", cs_low, 36);
    check_eq("t1_frame_len", cs_rise_cyc - acc_cyc, 38);

    // slave 2 mode 3 then slave 1 mode 0, miso high
    loop_en = 1'b0; miso_fix = 1'b1;
    clear_mon();
    send(8'h5A, 4'd2, 1'b1);
    check_eq("t2_prep_cpol1", sclk, 1);
    check_eq("t2_prep_cs", n_cs_bus, 3'b111);
    wait_idle();
    check_eq("t2a_data", rx_q[0], 8'hFF);
    check_eq("t2a_slave", sl_q[0], 2);
    check_eq("t2a_cs_pat", low_pat, 3'b011);
    check_eq("t2_idle_hi", sclk, 1);
    clear_mon();
    send(8'h00, 4'd1, 1'b1);
    check_eq("t2_prep_cpol0", sclk, 0);
    check_eq("t2b_prep_cs", n_cs_bus, 3'b111);
    wait_idle();
    check_eq("t2b_data", rx_q[0], 8'hFF);
    check_eq("t2b_slave", sl_q[0], 1);
    check_eq("t2b_cs_pat", low_pat, 3'b101);

    // three-byte frame with a 20-cycle underrun stall before byte 2
    loop_en = 1'b1;
    clear_mon();
    send(8'h12, 4'd0, 1'b0);
    wait_next();
    bad = 0;
    repeat (20) begin
      @(negedge sclk_common);
      if (n_cs_bus !== 3'b110 || sclk !== 1'b0) bad++;
    end
    check_eq("t3_stall_hold", bad, 0);
    send(8'h34, 4'd2, 1'b0);
    send(8'h56, 4'd0, 1'b1);
    wait_idle();
    check_eq("t3_svcnt", sv_cnt, 3);
    check_eq("t3_data", {rx_q[0], rx_q[1], rx_q[2]}, 24'h123456);
    check_eq("t3_last", {last_q[0], last_q[1], last_q[2]}, 3'b001);
    check_eq("t3_slave1", sl_q[1], 0);
    check_eq("t3_cs_rises", cs_rises, 1);

    // out-of-range slave index
    clear_mon();
    send(8'hFF, 4'd5, 1'b1);
    check_eq("t4_err", err, 1);
    check_eq("t4_busy", busy, 0);
    check_eq("t4_ncs", n_cs_bus, 3'b111);
    repeat (10) @(negedge sclk_common);
    check_eq("t4_err_cnt", err_cnt, 1);
    check_eq("t4_busy_cnt", busy_cnt, 0);
    check_eq("t4_cs_low", cs_low, 0);

    // reset during the 5th SHIFT half-period
    clear_mon();
    send(8'hC3, 4'd0, 1'b1);
    repeat (12) @(posedge sclk_common);
    #3;
    check_eq("t5_pre_busy", busy, 1);
    check_eq("t5_pre_ncs", n_cs_bus, 3'b110);
    n_rst = 1'b0;
    #1;
    check_eq("t5_rst_ncs", n_cs_bus, 3'b111);
    check_eq("t5_rst_sclk", sclk, 0);
    check_eq("t5_rst_busy", busy, 0);
    check_eq("t5_rst_ready", m_ready, 1);
    repeat (3) @(negedge sclk_common);
    n_rst = 1'b1;
    check_eq("t5_no_valid", sv_cnt, 0);
    send(8'h3C, 4'd0, 1'b1);
    wait_idle();
    check_eq("t5_after_cnt", sv_cnt, 1);
    check_eq("t5_after_data", rx_q[0], 8'h3C);

`ifdef SPI_3WIRE_EN
    clear_mon();
    oe_sv.delete();
    oe_hi = 0;
    send(8'h81, 4'd0, 1'b0);
    send(8'h00, 4'd0, 1'b1);
    wait_idle();
    check_eq("t6_svcnt", sv_cnt, 2);
    check_eq("t6_oe_was_hi", oe_hi > 0, 1);
    check_eq("t6_oe_after8", oe_sv[0], 0);
    check_eq("t6_rx2", rx_q[1], 8'h3C);
    check_eq("t6_oe_end", sdio_oe, 0);
`endif

    check_eq("one_cs_low", multi_low, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
